// File: rtl/mem_access_stage_if.sv
// Signal bundle around the memory-access stage: upstream instruction handoff,
// the data-memory request/acknowledge bus and the write-back packet.
interface mem_access_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] insn;
    logic [31:0] alu_result;
    logic [31:0] rt_value;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        addr_error;
    logic        bus_error;

    modport slave (
        input  in_valid, insn, alu_result, rt_value, mem_rdata, mem_ack,
        output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               wb_valid, wb_en, wb_reg, wb_data, addr_error, bus_error
    );

    modport master (
        output in_valid, insn, alu_result, rt_value, mem_rdata, mem_ack,
        input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               wb_valid, wb_en, wb_reg, wb_data, addr_error, bus_error
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns loads/stores into a req/ack data-memory
// transaction and emits one registered write-back packet per instruction.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic              clock,
    input  logic              reset,
    mem_access_stage_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [5:0]       op_q, op_d;
    logic [1:0]       lane_q, lane_d;
    logic [4:0]       dest_q, dest_d;
    logic             dest_en_q, dest_en_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       wb_reg_q, wb_reg_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             addr_error_q, addr_error_d;
    logic             bus_error_q, bus_error_d;

    logic [5:0]  opcode;
    logic [4:0]  dec_dest;
    logic        dec_writes;
    logic        dec_dest_en;
    logic        dec_is_store;
    logic        dec_is_mem;
    logic        dec_misaligned;
    logic [7:0]  lane_byte;
    logic [31:0] load_value;
    logic        unused_insn_bits;

    assign opcode           = bus.insn[31:26];
    assign unused_insn_bits = ^{bus.insn[25:21], bus.insn[10:6]};

    // Destination decode: only the listed writers produce a register write, r0 never does.
    always_comb begin
        dec_dest   = 5'd0;
        dec_writes = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (bus.insn[5:0] != FN_JR) begin
                    dec_dest   = bus.insn[15:11];
                    dec_writes = 1'b1;
                end
            end
            OP_LW, OP_LB, OP_LBU, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ORI, OP_XORI, OP_LUI: begin
                dec_dest   = bus.insn[20:16];
                dec_writes = 1'b1;
            end
            OP_JAL: begin
                dec_dest   = 5'd31;
                dec_writes = 1'b1;
            end
            default: ;
        endcase
        dec_dest_en    = dec_writes && (dec_dest != 5'd0);
        dec_is_store   = (opcode == OP_SW) || (opcode == OP_SB);
        dec_is_mem     = dec_is_store || (opcode == OP_LW) || (opcode == OP_LB) ||
                         (opcode == OP_LBU);
        dec_misaligned = ((opcode == OP_LW) || (opcode == OP_SW)) &&
                         (bus.alu_result[1:0] != 2'b00);
    end

    // Big-endian lane pick: lane 0 is the most significant byte.
    always_comb begin
        case (lane_q)
            2'd0:    lane_byte = rdata_q[31:24];
            2'd1:    lane_byte = rdata_q[23:16];
            2'd2:    lane_byte = rdata_q[15:8];
            default: lane_byte = rdata_q[7:0];
        endcase
        case (op_q)
            OP_LB:   load_value = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_value = {24'd0, lane_byte};
            default: load_value = rdata_q;
        endcase
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        lane_d       = lane_q;
        dest_d       = dest_q;
        dest_en_d    = dest_en_q;
        rdata_d      = rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_en_d      = 1'b0;
        wb_reg_d     = wb_reg_q;
        wb_data_d    = wb_data_q;
        addr_error_d = 1'b0;
        bus_error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!dec_is_mem || dec_misaligned) begin
                        wb_valid_d   = 1'b1;
                        wb_en_d      = dec_dest_en && !dec_is_mem;
                        wb_reg_d     = dec_dest;
                        wb_data_d    = bus.alu_result;
                        addr_error_d = dec_misaligned;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        op_d        = opcode;
                        lane_d      = bus.alu_result[1:0];
                        dest_d      = dec_dest;
                        dest_en_d   = dec_dest_en;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dec_is_store;
                        mem_addr_d  = {bus.alu_result[31:2], 2'b00};
                        mem_be_d    = (opcode == OP_SB) ? (4'b1000 >> bus.alu_result[1:0])
                                                        : 4'b1111;
                        mem_wdata_d = (opcode == OP_SB) ? {4{bus.rt_value[7:0]}}
                                    : (opcode == OP_SW) ? bus.rt_value : 32'd0;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    rdata_d   = bus.mem_rdata;
                    mem_req_d = 1'b0;
                end else if (cnt_inc == CNT_LIMIT) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    wb_valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d    = IDLE;
                cnt_d      = '0;
                wb_valid_d = 1'b1;
                wb_en_d    = dest_en_q && !mem_we_q;
                wb_reg_d   = dest_q;
                wb_data_d  = load_value;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a flop, so async reset forces the idle values at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= 6'd0;
            lane_q       <= 2'd0;
            dest_q       <= 5'd0;
            dest_en_q    <= 1'b0;
            rdata_q      <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_reg_q     <= 5'd0;
            wb_data_q    <= 32'd0;
            addr_error_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            dest_q       <= dest_d;
            dest_en_q    <= dest_en_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_en_q      <= wb_en_d;
            wb_reg_q     <= wb_reg_d;
            wb_data_q    <= wb_data_d;
            addr_error_q <= addr_error_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_reg     = wb_reg_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.addr_error = addr_error_q;
    assign bus.bus_error  = bus_error_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute ALU.
- Consumes the ALU result and the instruction word. For loads and stores, the ALU result is the effective address. For all other instructions it is the value to write back.
- Runs a request/acknowledge transaction with data memory, then presents a registered write-back packet (data, destination register, enable) to the writeback stage.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ waiting for mem_ack before aborting.
- CNT_W, 5: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  stage clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- insn  in  32  instruction word
- alu_result  in  32  ALU dataOut (address or result)
- rt_value  in  32  rt register value (store data)
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned address (low 2 bits forced to 0)
- mem_be  out  4  byte enables; bit3 = bits 31:24
- mem_wdata  out  32  store data, placed in the correct byte lane
- mem_rdata  in  32  read data, valid when mem_ack is high
- mem_ack  in  1  one-cycle completion pulse
- wb_valid  out  1  one-cycle pulse: write-back packet valid
- wb_en  out  1  register write enable for the packet
- wb_reg  out  5  destination register
- wb_data  out  32  write-back data
- addr_error  out  1  one-cycle pulse: misaligned LW/SW
- bus_error  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (asynchronous): state = IDLE, counter = 0. All outputs drop immediately to 0, except in_ready = 1. Reset during REQ abandons the transaction; mem_req falls without waiting for a clock edge.
- Acceptance: an instruction is accepted in the cycle where in_valid && in_ready. insn, alu_result and rt_value are captured on that edge.
- Opcodes (insn[31:26]): LW 100011, LB 100000, LBU 100100, SW 101011, SB 101000.
- Byte order is big-endian: address[1:0] = 0 selects bits 31:24.
- Destination register:
  - R-type (opcode 0) writes rd.
  - Loads and I-type ALU ops (ADDI, ADDIU, SLTI, SLTIU, ORI, XORI, LUI) write rt.
  - JAL writes register 31.
  - Stores, branches, J and JR write nothing (wb_en = 0).
  - A destination of register 0 forces wb_en = 0.
- FSM states: IDLE, REQ, RESP.
  - IDLE, non-memory instruction accepted at cycle T: wb_valid = 1 at T+1, wb_data = alu_result. Stay in IDLE; back-to-back acceptance every cycle is allowed.
  - IDLE, misaligned LW/SW accepted (alu_result[1:0] != 0): no memory request. At T+1, addr_error = 1 and wb_valid = 1 with wb_en = 0. Stay in IDLE.
  - IDLE, aligned memory op accepted: go to REQ. mem_req = 1 from T+1.
  - REQ: mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable. The counter increments each cycle.
    - mem_ack sampled high: go to RESP and latch mem_rdata.
    - Counter reaches TIMEOUT_CYCLES with no ack: drop mem_req, pulse bus_error, pulse wb_valid with wb_en = 0, return to IDLE.
  - RESP (one cycle): wb_valid = 1. Clear the counter and return to IDLE; in_ready = 1 in the following cycle.
- Store formatting:
  - SW: mem_be = 1111, mem_wdata = rt_value.
  - SB: mem_be = one-hot lane (addr 0 -> 1000, 1 -> 0100, 2 -> 0010, 3 -> 0001). rt_value[7:0] is replicated into all four lanes.
- Load formatting:
  - LW returns the whole word.
  - LB selects the lane byte and sign-extends it.
  - LBU selects the lane byte and zero-extends it.
  - Reads drive mem_be = 1111.
- Minimum latency for a memory op: ack in the first REQ cycle gives wb_valid at T+3.
- mem_ack seen while not in REQ is ignored.
- in_ready is low during REQ and RESP; upstream holds its inputs.

Test Plan:
- Reset, then ADDU writing rd = 5 with alu_result 0x0000_0007 accepted at T -> at T+1: wb_valid = 1, wb_en = 1, wb_reg = 5, wb_data = 7; in_ready stays 1.
- LB, address 0x0000_0102, mem_rdata 0x1122_F344, ack after 2 REQ cycles -> mem_be = 1111, mem_addr = 0x100; wb_data = 0xFFFF_FFF3. Repeat as LBU -> wb_data = 0x0000_00F3.
- SB, address 0x0000_0041, rt_value 0x0000_00AB -> mem_we = 1, mem_be = 0100, mem_wdata = 0xABAB_ABAB; wb_valid = 1 with wb_en = 0 one cycle after ack.
- LW, address 0x0000_0006 -> no mem_req ever asserted; addr_error pulses at T+1; wb_en = 0.
- LW, address 0x200, mem_ack never asserted -> mem_req high for exactly TIMEOUT_CYCLES (16) cycles, then bus_error and wb_valid pulse; in_ready returns to 1.
- Reset asserted mid-REQ -> mem_req = 0 and in_ready = 1 with no clock edge. A later stray mem_ack produces no wb_valid.
